// File: rtl/sm_muldiv_if.sv
// Command/result bundle between the CPU and the HI/LO multiply-divide unit.
// Latency: n/a (wires only).
// Backpressure: the CPU holds new commands while busy is high.
interface sm_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // CPU side: issues commands, reads HI/LO.
  modport master (
    output start, op, srcA, srcB,
    input  busy, done, hi, lo
  );

  // Unit side.
  modport slave (
    input  start, op, srcA, srcB,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/sm_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers plus MTHI/MTLO; divider built only with SM_MULDIV_DIV_EN.
// Latency: WIDTH+1 cycles for mul/div (WIDTH radix-2 steps + sign fix); MTHI/MTLO land at the sampling edge.
// Backpressure: busy is high for the whole operation; start is ignored while busy.
module sm_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  sm_muldiv_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hiR, loR;
  // Multiply: {workHi,workLo} is the running product, workLo starts as |multiplier|.
  // Divide:   workHi is the partial remainder, workLo the dividend turning into the quotient.
  logic [WIDTH-1:0] workHi, workLo;
  logic [WIDTH-1:0] opnd;       // |multiplicand| or |divisor|
  logic             sA, sB;     // original operand signs (0 for unsigned ops)
  logic             doneR;

  logic             signedOp;
  logic [WIDTH-1:0] absA, absB;
  logic [WIDTH:0]   mulAcc;
  logic [2*WIDTH-1:0] prodFix;

`ifdef SM_MULDIV_DIV_EN
  logic             isDiv;
  logic [WIDTH:0]   divShift, divDiff;
  logic [WIDTH-1:0] quoFix, remFix;
`endif

  // Operand magnitudes, one shift-add step and the signed product fixup.
  always_comb begin
    signedOp = ~bus.op[0];
    absA     = (signedOp && bus.srcA[WIDTH-1]) ? -bus.srcA : bus.srcA;
    absB     = (signedOp && bus.srcB[WIDTH-1]) ? -bus.srcB : bus.srcB;
    mulAcc   = {1'b0, workHi} + {1'b0, (workLo[0] ? opnd : {WIDTH{1'b0}})};
    prodFix  = (sA ^ sB) ? -{workHi, workLo} : {workHi, workLo};
  end

`ifdef SM_MULDIV_DIV_EN
  // One restoring-division step and the quotient/remainder sign fixup.
  // With a zero divisor every trial subtract succeeds, so the remainder ends up
  // holding |dividend| again and remFix restores the latched srcA exactly.
  always_comb begin
    divShift = {workHi, workLo[WIDTH-1]};
    divDiff  = divShift - {1'b0, opnd};
    quoFix   = (sA ^ sB) ? -workLo : workLo;
    remFix   = sA ? -workHi : workHi;
  end
`endif

  // Command decode, iteration sequencing and HI/LO update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      hiR    <= '0;
      loR    <= '0;
      workHi <= '0;
      workLo <= '0;
      opnd   <= '0;
      sA     <= 1'b0;
      sB     <= 1'b0;
      doneR  <= 1'b0;
`ifdef SM_MULDIV_DIV_EN
      isDiv  <= 1'b0;
`endif
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.op)
              3'd0, 3'd1: begin
                state  <= CALC;
                cnt    <= '0;
                sA     <= signedOp & bus.srcA[WIDTH-1];
                sB     <= signedOp & bus.srcB[WIDTH-1];
                opnd   <= absA;
                workHi <= '0;
                workLo <= absB;
`ifdef SM_MULDIV_DIV_EN
                isDiv  <= 1'b0;
`endif
              end
`ifdef SM_MULDIV_DIV_EN
              3'd2, 3'd3: begin
                state  <= CALC;
                cnt    <= '0;
                sA     <= signedOp & bus.srcA[WIDTH-1];
                sB     <= signedOp & bus.srcB[WIDTH-1];
                opnd   <= absB;
                workHi <= '0;
                workLo <= absA;
                isDiv  <= 1'b1;
              end
`endif
              3'd4:    hiR <= bus.srcA;
              3'd5:    loR <= bus.srcA;
              default: ;
            endcase
          end
        end

        CALC: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
`ifdef SM_MULDIV_DIV_EN
          if (isDiv) begin
            if (!divDiff[WIDTH]) begin
              workHi <= divDiff[WIDTH-1:0];
              workLo <= {workLo[WIDTH-2:0], 1'b1};
            end else begin
              workHi <= divShift[WIDTH-1:0];
              workLo <= {workLo[WIDTH-2:0], 1'b0};
            end
          end else begin
            workHi <= mulAcc[WIDTH:1];
            workLo <= {mulAcc[0], workLo[WIDTH-1:1]};
          end
`else
          workHi <= mulAcc[WIDTH:1];
          workLo <= {mulAcc[0], workLo[WIDTH-1:1]};
`endif
        end

        FIX: begin
          state <= IDLE;
          doneR <= 1'b1;
`ifdef SM_MULDIV_DIV_EN
          if (isDiv) begin
            hiR <= remFix;
            loR <= (opnd == '0) ? {WIDTH{1'b1}} : quoFix;
          end else begin
            hiR <= prodFix[2*WIDTH-1:WIDTH];
            loR <= prodFix[WIDTH-1:0];
          end
`else
          hiR <= prodFix[2*WIDTH-1:WIDTH];
          loR <= prodFix[WIDTH-1:0];
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = doneR;
  assign bus.hi   = hiR;
  assign bus.lo   = loR;

endmodule

// File: tb/tb_sm_muldiv.sv
// Randomised + directed bench for sm_muldiv (WIDTH=32) against an arithmetic HI/LO model.
// Latency: checks result arrival exactly WIDTH+1 cycles after the start edge.
// Backpressure: injects ignored starts while busy and issues back-to-back commands.
module tb_sm_muldiv;

`ifdef SM_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nTests = 0;
  int   nFail = 0;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  sm_muldiv_if #(.WIDTH(W)) bus ();

  sm_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {hi, lo} as the architecture defines it, straight from integer arithmetic.
  function automatic logic [63:0] refResult(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     q, r;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
      end
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {mHi, mLo};
    endcase
  endfunction

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one command and check it; returns in the cycle after it completes,
  // so the next call's start lands in the done cycle (back-to-back).
  task automatic runCmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    logic [63:0] r;
    bit          calc;
    bit          gotDone;
    int          k, busyCnt;
    calc = (op < 3'd2) || (DIV_EN && (op == 3'd2 || op == 3'd3));
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.srcA  = a;
    bus.srcB  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.srcA  = $urandom;
    bus.srcB  = $urandom;
    check("done_low_after_start", {63'b0, bus.done}, 64'd0);
    if (!calc) begin
      if (op == 3'd4) mHi = a;
      if (op == 3'd5) mLo = a;
      check("busy_single_cycle_op", {63'b0, bus.busy}, 64'd0);
      check("hi_single_cycle_op", {32'b0, bus.hi}, {32'b0, mHi});
      check("lo_single_cycle_op", {32'b0, bus.lo}, {32'b0, mLo});
      return;
    end
    r = refResult(op, a, b);
    busyCnt = 0;
    gotDone = 1'b0;
    k = 0;
    while (!gotDone && k < 80) begin
      if (bus.busy) busyCnt++;
      if (inject && k == 10) begin
        bus.start = 1'b1;
        bus.op    = 3'd5;
        bus.srcA  = $urandom;
      end
      if (inject && k == 11) bus.start = 1'b0;
      @(posedge clk);
      #1;
      k++;
      gotDone = bus.done;
    end
    bus.start = 1'b0;
    check("done_latency", 64'(k), 64'(W + 1));
    check("busy_cycles", 64'(busyCnt), 64'(W + 1));
    check("busy_low_at_done", {63'b0, bus.busy}, 64'd0);
    check("hi_result", {32'b0, bus.hi}, {32'b0, r[63:32]});
    check("lo_result", {32'b0, bus.lo}, {32'b0, r[31:0]});
    mHi = r[63:32];
    mLo = r[31:0];
  endtask

  // Reset in the middle of a long operation must discard it completely.
  task automatic midOpReset();
    bit doneSeen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = DIV_EN ? 3'd3 : 3'd1;
    bus.srcA  = 32'd1000;
    bus.srcB  = 32'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_hi", {32'b0, bus.hi}, 64'd0);
    check("rst_lo", {32'b0, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mHi = '0;
    mLo = '0;
    doneSeen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      doneSeen |= bus.done;
    end
    check("no_done_after_rst", {63'b0, doneSeen}, 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.srcA  = '0;
    bus.srcB  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, bus.busy}, 64'd0);
    check("reset_done", {63'b0, bus.done}, 64'd0);
    check("reset_hi", {32'b0, bus.hi}, 64'd0);
    check("reset_lo", {32'b0, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    runCmd(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    runCmd(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    runCmd(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    runCmd(3'd3, 32'd7, 32'd0, 1'b0);
    runCmd(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    runCmd(3'd2, 32'h8000_0005, 32'd0, 1'b0);
    runCmd(3'd4, 32'h1234_5678, 32'd0, 1'b0);
    runCmd(3'd1, 32'd2, 32'd3, 1'b1);
    runCmd(3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    runCmd(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
    runCmd(3'd3, 32'd9, 32'd3, 1'b0);
    runCmd(3'd1, 32'd4, 32'd5, 1'b0);

    midOpReset();
    runCmd(3'd3, 32'd100, 32'd7, 1'b0);

    // Randomised mix of all commands
    for (int i = 0; i < 40; i++) begin
      runCmd(3'($urandom_range(0, 7)), pickVal(), pickVal(), ($urandom_range(0, 3) == 0));
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
